// File: rtl/rc4_stream.sv
// RC4 keystream generator: serial key load, 256-cycle S init, 512-cycle KSA,
// then one keystream byte every 4 cycles behind a valid/ready handshake.
module rc4_stream #(
   parameter int MAX_KEY_BYTES = 16,
   parameter int DISCARD_W     = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [7:0]           key_len,
   input  logic [DISCARD_W-1:0] discard_n,
   input  logic                 key_valid,
   input  logic [7:0]           key_byte,
   output logic                 key_ready,
   output logic                 out_valid,
   output logic [7:0]           out_byte,
   input  logic                 out_ready,
   output logic                 busy
);
   localparam int KW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

   typedef enum logic [3:0] {
      IDLE, KEYLOAD, INIT, KSA_J, KSA_SWAP, PRGA_J, PRGA_SWAP, PRGA_OUT, STREAM
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           s_q   [256];
   logic [7:0]           key_q [MAX_KEY_BYTES];
   logic [7:0]           i_q, j_q;
   logic [KW-1:0]        kidx_q, klen_q, klen_d;
   logic [DISCARD_W-1:0] disc_q;
   logic [7:0]           out_byte_q;
   logic                 out_valid_q, key_ready_q, busy_q;

   logic [7:0]           i_inc, si, sj, k_idx, ksa_j_d, prga_j_d, k_d;
   logic                 start_ok, key_last;

   assign i_inc    = i_q + 8'd1;
   assign si       = s_q[i_q];
   assign sj       = s_q[j_q];
   assign k_idx    = si + sj;
   assign k_d      = s_q[k_idx];
   assign ksa_j_d  = j_q + si + key_q[kidx_q];
   assign prga_j_d = j_q + s_q[i_inc];
   assign key_last = (kidx_q == klen_q);
   assign start_ok = start && ((state_q == IDLE) || (state_q == STREAM));
   assign klen_d   = ({24'd0, key_len} >= 32'(MAX_KEY_BYTES)) ? KW'(MAX_KEY_BYTES - 1)
                                                              : KW'(key_len);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start_ok) state_d = KEYLOAD;
         KEYLOAD:   if (key_valid && key_last) state_d = INIT;
         INIT:      if (i_q == 8'hFF) state_d = KSA_J;
         KSA_J:     state_d = KSA_SWAP;
         KSA_SWAP:  state_d = (i_q == 8'hFF) ? PRGA_J : KSA_J;
         PRGA_J:    state_d = PRGA_SWAP;
         PRGA_SWAP: state_d = PRGA_OUT;
         PRGA_OUT:  state_d = (disc_q != '0) ? PRGA_J : STREAM;
         STREAM: begin
            // a new session takes priority; the pending byte counts as consumed
            if (start_ok)       state_d = KEYLOAD;
            else if (out_ready) state_d = PRGA_J;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         i_q         <= '0;
         j_q         <= '0;
         kidx_q      <= '0;
         klen_q      <= '0;
         disc_q      <= '0;
         out_byte_q  <= '0;
         out_valid_q <= 1'b0;
         key_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_ready_q <= (state_d == KEYLOAD);
         busy_q      <= (state_d != IDLE);
         if (start_ok) begin
            klen_q      <= klen_d;
            disc_q      <= discard_n;
            kidx_q      <= '0;
            out_valid_q <= 1'b0;
         end else begin
            case (state_q)
               KEYLOAD: begin
                  if (key_valid) begin
                     kidx_q <= kidx_q + KW'(1);
                     if (key_last) i_q <= '0;
                  end
               end
               INIT: begin
                  i_q <= i_inc;
                  if (i_q == 8'hFF) begin
                     j_q    <= '0;
                     kidx_q <= '0;
                  end
               end
               KSA_J: j_q <= ksa_j_d;
               KSA_SWAP: begin
                  kidx_q <= key_last ? '0 : kidx_q + KW'(1);
                  i_q    <= i_inc;
                  if (i_q == 8'hFF) j_q <= '0;
               end
               PRGA_J: begin
                  i_q <= i_inc;
                  j_q <= prga_j_d;
               end
               PRGA_OUT: begin
                  if (disc_q != '0) begin
                     disc_q <= disc_q - DISCARD_W'(1);
                  end else begin
                     out_byte_q  <= k_d;
                     out_valid_q <= 1'b1;
                  end
               end
               STREAM: if (out_ready) out_valid_q <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   // S and key are plain storage: never reset, rewritten by every session
   always_ff @(posedge clk) begin
      case (state_q)
         KEYLOAD: if (key_valid && !start_ok) key_q[kidx_q] <= key_byte;
         INIT:    s_q[i_q] <= i_q;
         KSA_SWAP, PRGA_SWAP: begin
            s_q[i_q] <= sj;
            s_q[j_q] <= si;
         end
         default: ;
      endcase
   end

   assign key_ready = key_ready_q;
   assign out_valid = out_valid_q;
   assign out_byte  = out_byte_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_rc4_stream.sv
// Randomized bench for rc4_stream against a plain RC4 reference model.
module tb_rc4_stream;
   localparam int MAXK = 16;
   localparam int DW   = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    key_len = '0;
   logic [DW-1:0] discard_n = '0;
   logic          key_valid = 1'b0;
   logic [7:0]    key_byte = '0;
   logic          out_ready = 1'b0;
   logic          key_ready, out_valid, busy;
   logic [7:0]    out_byte;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] key_buf [256];
   logic [7:0] exp_q [$];

   rc4_stream #(.MAX_KEY_BYTES(MAXK), .DISCARD_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len),
      .discard_n(discard_n), .key_valid(key_valid), .key_byte(key_byte),
      .key_ready(key_ready), .out_valid(out_valid), .out_byte(out_byte),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // textbook RC4: KSA over the key, then PRGA, dropping the first disc bytes
   task automatic rc4_model(input int klen, input int disc, input int n);
      logic [7:0] s [256];
      logic [7:0] t;
      int i, j, a;
      exp_q.delete();
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      j = 0;
      for (int x = 0; x < 256; x++) begin
         j = (j + int'(s[x]) + int'(key_buf[x % klen])) % 256;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      i = 0; j = 0;
      for (int x = 0; x < disc + n; x++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         a = (int'(s[i]) + int'(s[j])) % 256;
         if (x >= disc) exp_q.push_back(s[a]);
      end
   endtask

   // Runs one session; leaves the last of nbytes on out_byte unaccepted.
   task automatic session(input logic [7:0] klen_field, input int disc, input int nbytes,
                          input int ready_pct, input bit glitch_init, input bit start_ready);
      int eff, cyc, kc, expected, w, gap, tries;
      bit r;
      eff = (int'(klen_field) + 1 > MAXK) ? MAXK : int'(klen_field) + 1;
      rc4_model(eff, disc, nbytes);

      w = 0;
      while (busy && !out_valid && w < 200) begin tick(); w++; end
      check("start_window", {31'd0, (!busy || out_valid)}, 1);

      start = 1'b1; key_len = klen_field; discard_n = DW'(disc);
      key_valid = 1'b0; out_ready = start_ready;
      tick();
      start = 1'b0; out_ready = 1'b0; cyc = 0;
      check("key_ready", {31'd0, key_ready}, 1);
      check("ov_cleared", {31'd0, out_valid}, 0);

      for (int b = 0; b < eff; b++) begin
         while (ready_pct < 100 && $urandom_range(3) == 0) begin
            key_valid = 1'b0; key_byte = 8'($urandom);
            tick(); cyc++;
         end
         key_valid = 1'b1; key_byte = key_buf[b];
         tick(); cyc++;
      end
      key_valid = 1'b0;
      kc = cyc;
      expected = kc + 256 + 512 + 3 * (disc + 1);

      while (!out_valid && cyc < expected + 20) begin
         key_valid = 1'($urandom_range(1));
         key_byte = 8'($urandom);
         if (glitch_init && cyc == kc + 10) begin
            start = 1'b1; key_len = 8'd0; discard_n = DW'(7);
         end else begin
            start = 1'b0;
         end
         tick(); cyc++;
      end
      start = 1'b0; key_valid = 1'b0;
      check("latency", cyc, expected);
      check("busy", {31'd0, busy}, 1);

      for (int k = 0; k < nbytes; k++) begin
         if (k > 0) begin
            gap = 0;
            while (!out_valid && gap < 20) begin tick(); gap++; end
            if (ready_pct == 100) check("throughput", gap + 1, 4);
         end
         check($sformatf("valid%0d", k), {31'd0, out_valid}, 1);
         check($sformatf("byte%0d", k), out_byte, exp_q[k]);
         if (k == nbytes - 1) break;
         tries = 0;
         do begin
            r = ($urandom_range(99) < ready_pct) || (tries >= 20);
            out_ready = r;
            tick(); tries++;
            if (!r) begin
               check("hold_valid", {31'd0, out_valid}, 1);
               check("hold_byte", out_byte, exp_q[k]);
            end
         end while (!r);
         out_ready = 1'b0;
      end
   endtask

   task automatic load_key3();
      key_buf[0] = 8'h4B; key_buf[1] = 8'h65; key_buf[2] = 8'h79;
   endtask

   task automatic load_wiki();
      key_buf[0] = 8'h57; key_buf[1] = 8'h69; key_buf[2] = 8'h6B; key_buf[3] = 8'h69;
   endtask

   initial begin
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_byte", out_byte, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_key_ready", {31'd0, key_ready}, 0);
      #10 rst_n = 1'b1;
      tick();
      check("idle_busy", {31'd0, busy}, 0);

      load_key3();
      session(8'd2, 0, 10, 100, 1'b0, 1'b0);
      load_wiki();
      session(8'd3, 0, 6, 100, 1'b0, 1'b0);
      load_key3();
      session(8'd2, 3, 3, 100, 1'b0, 1'b0);
      load_wiki();
      session(8'd3, 0, 6, 40, 1'b0, 1'b0);

      // abort a session mid-KSA, then rerun from scratch
      load_key3();
      start = 1'b1; key_len = 8'd2; discard_n = '0;
      tick();
      start = 1'b0;
      for (int b = 0; b < 3; b++) begin
         key_valid = 1'b1; key_byte = key_buf[b]; tick();
      end
      key_valid = 1'b0;
      repeat (356) tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_key_ready", {31'd0, key_ready}, 0);
      repeat (3) tick();
      check("abort_hold_valid", {31'd0, out_valid}, 0);
      rst_n = 1'b1;
      repeat (5) tick();
      check("post_rst_idle", {31'd0, busy}, 0);
      session(8'd2, 0, 4, 100, 1'b0, 1'b0);

      // restart from STREAM on the accepting edge, with a stray start during INIT
      load_key3();
      session(8'd2, 0, 3, 100, 1'b0, 1'b0);
      load_wiki();
      session(8'd3, 0, 4, 100, 1'b1, 1'b1);

      for (int n = 0; n < 5; n++) begin
         for (int b = 0; b < MAXK; b++) key_buf[b] = 8'($urandom);
         session(8'($urandom_range(19)), int'($urandom_range(6)), 5,
                 int'($urandom_range(30, 100)), 1'b0, 1'($urandom_range(1)));
      end

      for (int b = 0; b < MAXK; b++) key_buf[b] = 8'($urandom);
      session(8'd7, (1 << DW) - 1, 2, 100, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
